// File: rtl/axis_video_sync_fifo_pkg.sv
// Shared types and constants for the video width-trim FIFO slice.
package axis_video_pkg;

  typedef enum logic [0:0] {
    RESYNC = 1'b0,
    PASS   = 1'b1
  } state_e;

  localparam int unsigned OVF_CNT_W = 16;
  localparam int unsigned FRM_CNT_W = 16;

  // Occupancy needs one extra bit so that a full FIFO (level == DEPTH) is representable.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_video_sync_fifo_if.sv
// AXI4-Stream video beat bundle (tdata/tvalid/tready/tlast/tuser).
interface axis_video_sync_fifo_if #(
  parameter int unsigned W = 8
) ();

  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/axis_video_sync_fifo_sync_fifo_fwft.sv
// First-word-fall-through FIFO: head word is visible one cycle after its write, no bypass.
module sync_fifo_fwft
  import axis_video_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 64
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          din,
  output logic                      full,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          dout,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;

  assign w_wr = wr_en && !full;
  assign w_rd = rd_en && !empty;

  // Idle output reads as zero so the reset-state data is defined without clearing the array.
  assign dout = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge aclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers are log2(DEPTH) wide, so wrap-around at DEPTH is the natural overflow.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/axis_video_sync_fifo.sv
// Video-input width-trim stage: keeps low OUT_W bits, buffers beats, resyncs to start-of-frame.
module axis_video_sync_fifo
  import axis_video_pkg::*;
#(
  parameter int unsigned IN_W         = 32,
  parameter int unsigned OUT_W        = 8,
  parameter int unsigned DEPTH        = 64,
  parameter bit          WAIT_SOF     = 1'b1,
  parameter bit          DROP_ON_FULL = 1'b1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axis_video_sync_fifo_if.slave     s_axis,
  axis_video_sync_fifo_if.master    m_axis,
  output logic [level_w(DEPTH)-1:0] fifo_level,
  output logic [OVF_CNT_W-1:0]      overflow_count,
  output logic [FRM_CNT_W-1:0]      frame_count,
  output logic                      in_sync
);

  localparam int unsigned WORD_W    = OUT_W + 2;
  localparam state_e      RST_STATE = WAIT_SOF ? RESYNC : PASS;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_active;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_wr_en;
  logic                  w_drop;
  logic                  w_rd_en;
  logic [WORD_W-1:0]     w_din;
  logic [WORD_W-1:0]     w_dout;
  logic [OVF_CNT_W-1:0]  r_ovf_cnt;
  logic [FRM_CNT_W-1:0]  r_frm_cnt;
  logic                  w_unused_tdata;

  // Registered enable keeps tready low throughout reset, even when the FIFO reads not-full.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  assign s_axis.tready  = r_active && (DROP_ON_FULL || !w_full);
  assign w_accept       = s_axis.tvalid && s_axis.tready;
  assign w_din          = {s_axis.tuser, s_axis.tlast, s_axis.tdata[OUT_W-1:0]};
  assign w_unused_tdata = ^s_axis.tdata;

  // Full is the registered occupancy: a beat meeting a full FIFO is dropped even if a read
  // frees a slot on the same edge.
  always_comb begin
    w_wr_en     = 1'b0;
    w_drop      = 1'b0;
    w_state_nxt = r_state;
    if (w_accept) begin
      case (r_state)
        RESYNC: begin
          if (s_axis.tuser) begin
            if (w_full) begin
              w_drop = 1'b1;
            end else begin
              w_wr_en     = 1'b1;
              w_state_nxt = PASS;
            end
          end
        end
        PASS: begin
          if (w_full) begin
            w_drop      = 1'b1;
            w_state_nxt = RESYNC;
          end else begin
            w_wr_en = 1'b1;
          end
        end
        default: w_state_nxt = RST_STATE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (w_wr_en),
    .din     (w_din),
    .full    (w_full),
    .rd_en   (w_rd_en),
    .dout    (w_dout),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  assign m_axis.tvalid = !w_empty;
  assign m_axis.tdata  = w_dout[OUT_W-1:0];
  assign m_axis.tlast  = w_dout[OUT_W];
  assign m_axis.tuser  = w_dout[OUT_W+1];
  assign w_rd_en       = m_axis.tvalid && m_axis.tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ovf_cnt <= '0;
      r_frm_cnt <= '0;
    end else begin
      if (w_drop && (r_ovf_cnt != '1)) begin
        r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
      end
      if (w_rd_en && m_axis.tuser) begin
        r_frm_cnt <= r_frm_cnt + FRM_CNT_W'(1);
      end
    end
  end

  assign overflow_count = r_ovf_cnt;
  assign frame_count    = r_frm_cnt;
  assign in_sync        = (r_state == PASS);

endmodule

// File: tb/tb_axis_video_sync_fifo.sv
// Scoreboard bench: DUT0 drops on full, DUT1 backpressures; both wait for SOF after reset.
module tb_axis_video_sync_fifo;
  import axis_video_pkg::*;

  localparam int unsigned IN_W  = 32;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = level_w(DEPTH);

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  logic [31:0] s_tdata  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast  = 1'b0;
  logic        s_tuser  = 1'b0;
  logic        m_tready = 1'b0;

  axis_video_sync_fifo_if #(.W(IN_W))  s0 ();
  axis_video_sync_fifo_if #(.W(IN_W))  s1 ();
  axis_video_sync_fifo_if #(.W(OUT_W)) m0 ();
  axis_video_sync_fifo_if #(.W(OUT_W)) m1 ();

  assign s0.tdata  = s_tdata;  assign s1.tdata  = s_tdata;
  assign s0.tvalid = s_tvalid; assign s1.tvalid = s_tvalid;
  assign s0.tlast  = s_tlast;  assign s1.tlast  = s_tlast;
  assign s0.tuser  = s_tuser;  assign s1.tuser  = s_tuser;
  assign m0.tready = m_tready; assign m1.tready = m_tready;

  logic [LW-1:0] lvl  [2];
  logic [15:0]   ovf  [2];
  logic [15:0]   frm  [2];
  logic          sync [2];

  axis_video_sync_fifo #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .WAIT_SOF(1'b1), .DROP_ON_FULL(1'b1)
  ) dut_drop (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s0), .m_axis(m0),
    .fifo_level(lvl[0]), .overflow_count(ovf[0]), .frame_count(frm[0]), .in_sync(sync[0])
  );

  axis_video_sync_fifo #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .WAIT_SOF(1'b1), .DROP_ON_FULL(1'b0)
  ) dut_bp (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s1), .m_axis(m1),
    .fifo_level(lvl[1]), .overflow_count(ovf[1]), .frame_count(frm[1]), .in_sync(sync[1])
  );

  logic       s_rdy  [2];
  logic       m_vld  [2];
  logic       m_last [2];
  logic       m_user [2];
  logic [7:0] m_data [2];
  assign s_rdy[0]  = s0.tready; assign s_rdy[1]  = s1.tready;
  assign m_vld[0]  = m0.tvalid; assign m_vld[1]  = m1.tvalid;
  assign m_last[0] = m0.tlast;  assign m_last[1] = m1.tlast;
  assign m_user[0] = m0.tuser;  assign m_user[1] = m1.tuser;
  assign m_data[0] = m0.tdata;  assign m_data[1] = m1.tdata;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic string tag(input int k, input string n);
    return $sformatf("dut%0d.%s", k, n);
  endfunction

  // Reference model: expected FIFO contents {tuser,tlast,data} per DUT.
  logic [9:0]  qa[$];
  logic [9:0]  qb[$];
  bit          mdl_pass   [2];
  bit          mdl_active [2];
  bit          mdl_acc    [2];
  logic [15:0] mdl_ovf    [2];
  logic [15:0] mdl_frm    [2];
  int unsigned obs_pops   [2];

  function automatic int unsigned qsize(input int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction

  function automatic logic [9:0] qfront(input int k);
    return (k == 0) ? qa[0] : qb[0];
  endfunction

  task automatic qpush(input int k, input logic [9:0] w);
    if (k == 0) qa.push_back(w);
    else        qb.push_back(w);
  endtask

  task automatic qpop(input int k);
    if (k == 0) void'(qa.pop_front());
    else        void'(qb.pop_front());
  endtask

  task automatic model_step(input int k);
    int unsigned sz;
    bit          full, exp_rdy, acc, wr, drop, rd;
    logic [9:0]  w, head;
    sz      = qsize(k);
    full    = (sz == DEPTH);
    exp_rdy = mdl_active[k] && ((k == 0) || !full);
    head    = (sz != 0) ? qfront(k) : 10'd0;
    check_eq(tag(k, "s_tready"), 32'(s_rdy[k]), 32'(exp_rdy));
    check_eq(tag(k, "m_tvalid"), 32'(m_vld[k]), 32'(sz != 0));
    check_eq(tag(k, "fifo_level"), 32'(lvl[k]), sz);
    check_eq(tag(k, "overflow_count"), 32'(ovf[k]), 32'(mdl_ovf[k]));
    check_eq(tag(k, "frame_count"), 32'(frm[k]), 32'(mdl_frm[k]));
    check_eq(tag(k, "in_sync"), 32'(sync[k]), 32'(mdl_pass[k]));
    if (sz != 0) begin
      check_eq(tag(k, "m_word"), 32'({m_user[k], m_last[k], m_data[k]}), 32'(head));
    end
    if (m_vld[k] && m_tready) obs_pops[k]++;

    acc  = s_tvalid && exp_rdy;
    w    = {s_tuser, s_tlast, s_tdata[7:0]};
    wr   = 1'b0;
    drop = 1'b0;
    if (acc) begin
      if (!mdl_pass[k]) begin
        if (s_tuser) begin
          if (full) drop = 1'b1;
          else begin
            wr          = 1'b1;
            mdl_pass[k] = 1'b1;
          end
        end
      end else if (full) begin
        drop        = 1'b1;
        mdl_pass[k] = 1'b0;
      end else begin
        wr = 1'b1;
      end
    end
    rd = (sz != 0) && m_tready;
    if (rd) begin
      if (head[9]) mdl_frm[k] = mdl_frm[k] + 16'd1;
      qpop(k);
    end
    if (wr) qpush(k, w);
    if (drop && (mdl_ovf[k] != 16'hFFFF)) mdl_ovf[k] = mdl_ovf[k] + 16'd1;
    mdl_acc[k] = acc;
  endtask

  task automatic cycle(input bit v, input logic [31:0] d, input bit last, input bit user, input bit rdy);
    @(negedge aclk);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = last;
    s_tuser  = user;
    m_tready = rdy;
    #1;
    model_step(0);
    model_step(1);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq(tag(k, "rst.m_tvalid"), 32'(m_vld[k]), 32'd0);
      check_eq(tag(k, "rst.m_word"), 32'({m_user[k], m_last[k], m_data[k]}), 32'd0);
      check_eq(tag(k, "rst.fifo_level"), 32'(lvl[k]), 32'd0);
      check_eq(tag(k, "rst.overflow_count"), 32'(ovf[k]), 32'd0);
      check_eq(tag(k, "rst.frame_count"), 32'(frm[k]), 32'd0);
      check_eq(tag(k, "rst.in_sync"), 32'(sync[k]), 32'd0);
      check_eq(tag(k, "rst.s_tready"), 32'(s_rdy[k]), 32'd0);
      mdl_pass[k]   = 1'b0;
      mdl_active[k] = 1'b0;
      mdl_ovf[k]    = '0;
      mdl_frm[k]    = '0;
    end
    qa.delete();
    qb.delete();
    repeat (2) @(negedge aclk);
    aresetn       = 1'b1;
    mdl_active[0] = 1'b1;
    mdl_active[1] = 1'b1;
  endtask

  int unsigned idx;
  logic [31:0] cur_d;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();

    // SOF wait after reset: non-SOF beats vanish, output starts at the tuser beat.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h1000_0000 + i, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hAABBCC11, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_0022, 1'b1, 1'b0, 1'b1);
    check_eq("A.first_out", 32'({m_user[0], m_last[0], m_data[0]}), 32'h211);
    check_eq("A.in_sync", 32'(sync[0]), 32'd1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    check_eq("A.second_out", 32'({m_user[0], m_last[0], m_data[0]}), 32'h122);
    repeat (2) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    check_eq("A.frame_count", 32'(frm[0]), 32'd1);

    // Overflow with stalled sink, then a beat against a full FIFO during a read.
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'hF0F0_0000 + i, 1'b0, i == 0, 1'b0);
    obs_pops[0] = 0;
    obs_pops[1] = 0;
    cycle(1'b1, 32'hBEEF_0001, 1'b0, 1'b1, 1'b1);
    check_eq("B.level0", 32'(lvl[0]), DEPTH);
    check_eq("B.ovf0", 32'(ovf[0]), 32'd1);
    check_eq("B.sync0", 32'(sync[0]), 32'd0);
    check_eq("B.level1", 32'(lvl[1]), DEPTH);
    check_eq("B.ovf1", 32'(ovf[1]), 32'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    check_eq("B.ovf0_full_read", 32'(ovf[0]), 32'd2);
    repeat (9) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    check_eq("B.drained0", obs_pops[0], DEPTH);
    check_eq("B.drained1", obs_pops[1], DEPTH);

    // Next frame's SOF after the drain is accepted; no tail of the dropped frame.
    cycle(1'b1, 32'h1234_565A, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_0060 + i, i == 2, 1'b0, 1'b1);
    check_eq("C.in_sync", 32'(sync[0]), 32'd1);
    repeat (4) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    // Backpressure: beat held until the non-dropping DUT takes it.
    idx   = 0;
    cur_d = 32'hD000_0000;
    for (int c = 0; c < 40; c++) begin
      cycle(1'b1, cur_d, 1'b0, 1'b0, c >= 20);
      if (c == 19) begin
        check_eq("D.level1", 32'(lvl[1]), DEPTH);
        check_eq("D.tready1", 32'(s_rdy[1]), 32'd0);
      end
      if (mdl_acc[1]) begin
        idx++;
        cur_d = 32'hD000_0000 + idx;
      end
    end
    repeat (10) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    // Long stream, sink ready every other cycle.
    idx   = 0;
    cur_d = $urandom();
    for (int c = 0; c < 1000 && idx < 200; c++) begin
      cycle(1'b1, cur_d, (idx % 10) == 9, (idx % 50) == 0, c[0] == 1'b0);
      if (mdl_acc[1]) begin
        idx++;
        cur_d = $urandom();
      end
    end
    check_eq("E.beats_sent", idx, 32'd200);
    repeat (12) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame with five beats buffered.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_00A0 + i, 1'b0, i == 0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    check_eq("F.level0_pre", 32'(lvl[0]), 32'd5);
    check_eq("F.level1_pre", 32'(lvl[1]), 32'd5);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_00B0 + i, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    check_eq("F.no_output0", 32'(m_vld[0]), 32'd0);
    cycle(1'b1, 32'h0000_0077, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_0088, 1'b1, 1'b0, 1'b1);
    check_eq("F.sof_out", 32'({m_user[1], m_last[1], m_data[1]}), 32'h277);
    repeat (4) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    check_eq("F.frame_count", 32'(frm[1]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
